// File: rtl/spi_flash_id_slave.sv
// rtl/spi_flash_id_slave.sv - SPI mode-0 slave answering W25Q-class 0x90/0x9F ID reads.
// All SPI pins are oversampled in sys_clk; actions land 3 sys_clk after a pin edge.
module spi_flash_id_slave #(
  parameter logic [7:0] MFR_ID   = 8'hEF,
  parameter logic [7:0] MEM_TYPE = 8'h40,
  parameter logic [7:0] CAPACITY = 8'h18,
  parameter logic [7:0] DEV_ID   = 8'h17
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       spi_csn,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       id_read_done
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_IGNORE} state_t;

  state_t      state, state_nxt;
  logic        csn_s1, csn_s2, csn_d;
  logic        sck_s1, sck_s2, sck_d;
  logic        mosi_s1, mosi_s2;
  logic [1:0]  sync_vld;
  logic        armed;
  logic [2:0]  bit_cnt;
  logic [1:0]  addr_cnt;
  logic [7:0]  rx_sr, tx_sr;
  logic [1:0]  ptr, ptr_nxt;
  logic        jedec, byte_done, sent, done_pend;
  logic        cs_low, cs_fall, cs_rise, sck_rise, sck_fall;
  logic        shift_en, tx_en, cmd_done, addr_done;
  logic [7:0]  tx_byte;

  // A CS fall only counts once the synchronizer holds real samples showing CS high,
  // so a reset in the middle of a frame cannot resume that frame.
  assign cs_low      = ~csn_s2;
  assign cs_fall     = cs_low & csn_d & armed;
  assign cs_rise     = csn_s2 & ~csn_d;
  assign sck_rise    = cs_low & sck_s2 & ~sck_d;
  assign sck_fall    = cs_low & ~sck_s2 & sck_d;
  assign spi_miso_oe = cs_low;

  always_comb begin
    tx_byte = MFR_ID;
    ptr_nxt = ptr;
    if (jedec) begin
      case (ptr)
        2'd0:    tx_byte = MFR_ID;
        2'd1:    tx_byte = MEM_TYPE;
        default: tx_byte = CAPACITY;
      endcase
      ptr_nxt = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    end else begin
      tx_byte = ptr[0] ? DEV_ID : MFR_ID;
      ptr_nxt = {1'b0, ~ptr[0]};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (cs_fall) state_nxt = S_CMD;
      S_CMD: begin
        if (byte_done) begin
          case (rx_sr)
            8'h90:   state_nxt = S_ADDR;
            8'h9F:   state_nxt = S_DATA;
            default: state_nxt = S_IGNORE;
          endcase
        end
      end
      S_ADDR:  if (byte_done && addr_cnt == 2'd2) state_nxt = S_DATA;
      default: state_nxt = state;
    endcase
    if (state != S_IDLE && cs_rise) state_nxt = S_IDLE;
  end

  always_comb begin
    shift_en  = sck_rise && (state == S_CMD || state == S_ADDR || state == S_DATA);
    tx_en     = sck_fall && (state == S_DATA);
    cmd_done  = byte_done && (state == S_CMD);
    addr_done = byte_done && (state == S_ADDR) && (addr_cnt == 2'd2);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      csn_s1 <= 1'b1; csn_s2 <= 1'b1; csn_d <= 1'b1;
      sck_s1 <= 1'b0; sck_s2 <= 1'b0; sck_d <= 1'b0;
      mosi_s1 <= 1'b0; mosi_s2 <= 1'b0;
      sync_vld <= 2'b00;
      armed <= 1'b0;
      bit_cnt <= 3'd0; addr_cnt <= 2'd0;
      rx_sr <= 8'h00; tx_sr <= 8'h00;
      ptr <= 2'd0; jedec <= 1'b0;
      byte_done <= 1'b0; sent <= 1'b0; done_pend <= 1'b0;
      spi_miso <= 1'b0; cmd_valid <= 1'b0; cmd_byte <= 8'h00; id_read_done <= 1'b0;
    end else begin
      csn_s1 <= spi_csn;  csn_s2 <= csn_s1;  csn_d <= csn_s2;
      sck_s1 <= spi_clk;  sck_s2 <= sck_s1;  sck_d <= sck_s2;
      mosi_s1 <= spi_mosi; mosi_s2 <= mosi_s1;
      sync_vld <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && csn_s2) armed <= 1'b1;

      byte_done    <= 1'b0;
      cmd_valid    <= 1'b0;
      done_pend    <= 1'b0;
      id_read_done <= done_pend;

      if (shift_en) begin
        rx_sr   <= {rx_sr[6:0], mosi_s2};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_done <= 1'b1;
          if (state == S_DATA) sent <= 1'b1;
        end
      end

      if (cmd_done) begin
        cmd_valid <= 1'b1;
        cmd_byte  <= rx_sr;
        jedec     <= (rx_sr == 8'h9F);
        ptr       <= 2'd0;
      end
      if (byte_done && state == S_ADDR) addr_cnt <= addr_cnt + 2'd1;
      if (addr_done) ptr <= {1'b0, rx_sr[0]};

      // bit_cnt is 0 on the fall right after a byte's last rise: load the next ID byte.
      if (tx_en) begin
        if (bit_cnt == 3'd0) begin
          spi_miso <= tx_byte[7];
          tx_sr    <= {tx_byte[6:0], 1'b0};
          ptr      <= ptr_nxt;
        end else begin
          spi_miso <= tx_sr[7];
          tx_sr    <= {tx_sr[6:0], 1'b0};
        end
      end else if (state != S_DATA) begin
        spi_miso <= 1'b0;
      end

      if (cs_rise && state != S_IDLE) begin
        done_pend <= sent;
        sent      <= 1'b0;
      end
      if (cs_fall) begin
        bit_cnt  <= 3'd0;
        addr_cnt <= 2'd0;
        sent     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_id_slave.sv
// tb/tb_spi_flash_id_slave.sv - scoreboard bench for spi_flash_id_slave.
module tb_spi_flash_id_slave;
  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       spi_csn = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe, cmd_valid, id_read_done;
  logic [7:0] cmd_byte;

  spi_flash_id_slave dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .spi_csn(spi_csn), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .id_read_done(id_read_done)
  );

  always #10 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int         vectors = 0, miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         cv_count = 0, cv_cyc = 0, ird_count = 0, ird_cyc = 0;
  logic [7:0] cv_byte = 8'h00;
  int         half = 6;
  int         rise_cyc = 0, cmd_rise_cyc = 0, csr_cyc = 0;
  logic       oe_seen = 1'b0;

  always @(negedge sys_clk) begin
    if (cmd_valid === 1'b1) begin
      cv_count++; cv_cyc = cyc; cv_byte = cmd_byte;
    end
    if (id_read_done === 1'b1) begin
      ird_count++; ird_cyc = cyc;
    end
  end

  task automatic xfer_bit(input logic b, output logic m);
    spi_mosi = b;
    repeat (half) @(negedge sys_clk);
    m = spi_miso;
    spi_clk = 1'b1;
    rise_cyc = cyc;
    repeat (half) @(negedge sys_clk);
    spi_clk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic m;
    for (int i = 7; i >= 0; i--) xfer_bit(b[i], m);
  endtask

  task automatic read_bits(input int n);
    logic [7:0] acc = 8'h00;
    logic m;
    for (int i = 0; i < n; i++) begin
      xfer_bit(1'b0, m);
      acc = {acc[6:0], m};
      if (i % 8 == 7) got_q.push_back(acc);
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [23:0] addr,
                           input bit has_addr, input int nbits);
    spi_csn = 1'b0;
    repeat (4) @(negedge sys_clk);
    send_byte(cmd);
    cmd_rise_cyc = rise_cyc;
    oe_seen = spi_miso_oe;
    if (has_addr) begin
      send_byte(addr[23:16]); send_byte(addr[15:8]); send_byte(addr[7:0]);
    end
    read_bits(nbits);
    spi_csn = 1'b1;
    csr_cyc = cyc;
    repeat (8) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; spi_csn = 1'b0;
    repeat (3) begin @(negedge sys_clk); spi_clk = ~spi_clk; end
    @(negedge sys_clk);
    vectors++; if (spi_miso !== 1'b0) begin miscompares++; $display("FAIL rst_miso: got %b want 0", spi_miso); end
    vectors++; if (spi_miso_oe !== 1'b0) begin miscompares++; $display("FAIL rst_oe: got %b want 0", spi_miso_oe); end
    vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_valid: got %b want 0", cmd_valid); end
    vectors++; if (cmd_byte !== 8'h00) begin miscompares++; $display("FAIL rst_cmd_byte: got %02h want 00", cmd_byte); end
    vectors++; if (id_read_done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", id_read_done); end
    spi_clk = 1'b0;
    sys_rst = 1'b0;
    send_byte(8'h9F); send_byte(8'h9F);
    spi_csn = 1'b1;
    repeat (8) @(negedge sys_clk);
    vectors++; if (cv_count !== 0) begin miscompares++; $display("FAIL rst_abort_cmd: got %0d cmd_valid want 0", cv_count); end
    vectors++; if (ird_count !== 0) begin miscompares++; $display("FAIL rst_abort_done: got %0d id_read_done want 0", ird_count); end
  endtask

  task automatic test_jedec();
    logic [7:0] e, g;
    int cv0 = cv_count, ird0 = ird_count;
    exp_q.push_back(8'hEF); exp_q.push_back(8'h40); exp_q.push_back(8'h18);
    exp_q.push_back(8'hEF); exp_q.push_back(8'h40);
    run_frame(8'h9F, 24'h0, 1'b0, 40);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      vectors++; if (g !== e) begin miscompares++; $display("FAIL jedec_byte: got %02h want %02h", g, e); end
    end
    vectors++; if (cv_count - cv0 !== 1) begin miscompares++; $display("FAIL jedec_cmd_count: got %0d want 1", cv_count - cv0); end
    vectors++; if (cv_byte !== 8'h9F) begin miscompares++; $display("FAIL jedec_cmd_byte: got %02h want 9f", cv_byte); end
    vectors++; if (cv_cyc - cmd_rise_cyc !== 4) begin miscompares++; $display("FAIL cmd_latency: got %0d want 4", cv_cyc - cmd_rise_cyc); end
    vectors++; if (oe_seen !== 1'b1) begin miscompares++; $display("FAIL jedec_oe: got %b want 1", oe_seen); end
    vectors++; if (ird_count - ird0 !== 1) begin miscompares++; $display("FAIL jedec_done: got %0d want 1", ird_count - ird0); end
    vectors++; if (ird_cyc - csr_cyc !== 4) begin miscompares++; $display("FAIL done_latency: got %0d want 4", ird_cyc - csr_cyc); end
    vectors++; if (spi_miso_oe !== 1'b0) begin miscompares++; $display("FAIL idle_oe: got %b want 0", spi_miso_oe); end
  endtask

  task automatic test_mfr_dev(input logic [23:0] addr, input int nbytes);
    logic [7:0] e, g;
    int ird0 = ird_count;
    for (int i = 0; i < nbytes; i++)
      exp_q.push_back(((i % 2) == int'(addr[0])) ? 8'hEF : 8'h17);
    run_frame(8'h90, addr, 1'b1, nbytes * 8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      vectors++; if (g !== e) begin miscompares++; $display("FAIL mfr_dev_byte a0=%b: got %02h want %02h", addr[0], g, e); end
    end
    vectors++; if (cv_byte !== 8'h90) begin miscompares++; $display("FAIL mfr_dev_cmd: got %02h want 90", cv_byte); end
    vectors++; if (ird_count - ird0 !== 1) begin miscompares++; $display("FAIL mfr_dev_done: got %0d want 1", ird_count - ird0); end
  endtask

  task automatic test_ignore();
    logic [7:0] e, g;
    int ird0 = ird_count;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    run_frame(8'h03, 24'h0, 1'b0, 16);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      vectors++; if (g !== e) begin miscompares++; $display("FAIL ignore_miso: got %02h want %02h", g, e); end
    end
    vectors++; if (cv_byte !== 8'h03) begin miscompares++; $display("FAIL ignore_cmd: got %02h want 03", cv_byte); end
    vectors++; if (ird_count !== ird0) begin miscompares++; $display("FAIL ignore_done: got %0d want %0d", ird_count, ird0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e, g;
    int ird0 = ird_count;
    half = 4;
    run_frame(8'h9F, 24'h0, 1'b0, 5);
    vectors++; if (got_q.size() !== 0) begin miscompares++; $display("FAIL abort_bytes: got %0d want 0", got_q.size()); end
    vectors++; if (ird_count !== ird0) begin miscompares++; $display("FAIL abort_done: got %0d want %0d", ird_count, ird0); end
    exp_q.push_back(8'hEF); exp_q.push_back(8'h40);
    run_frame(8'h9F, 24'h0, 1'b0, 16);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      vectors++; if (g !== e) begin miscompares++; $display("FAIL b2b_byte: got %02h want %02h", g, e); end
    end
    vectors++; if (ird_count - ird0 !== 1) begin miscompares++; $display("FAIL b2b_done: got %0d want 1", ird_count - ird0); end
    vectors++; if (got_q.size() !== 0) begin miscompares++; $display("FAIL b2b_extra: got %0d want 0", got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_jedec();
    test_mfr_dev(24'h000000, 2);
    test_mfr_dev(24'h000001, 3);
    test_ignore();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
